// File: rtl/arith_lab_pkg.sv
// arith_lab_pkg: shared FSM state type and default width for the arithmetic lab blocks
package arith_lab_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: start/done handshake, operands and result of the serial adder
interface serial_adder_if import arith_lab_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic cin;
  logic busy;
  logic done;
  logic [WIDTH-1:0] sum;
  logic cout;
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_full_adder.sv
// full_adder: one-bit gate-level full-adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic p, g, t;
  xor x0 (p, a, b);
  xor x1 (sum, p, cin);
  and a0 (g, a, b);
  and a1 (t, p, cin);
  or  o0 (cout, g, t);
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder, one full-adder cell plus carry flop
module serial_adder import arith_lab_pkg::*; #(parameter int WIDTH = DEF_WIDTH) (
  input  logic clk,
  input  logic rst_n,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  state_t state, next;
  logic [WIDTH-1:0] a_sr, b_sr, s_sr, sum_q;
  logic [CW-1:0] cnt;
  logic carry, cout_q, s, c, load, last;
  full_adder u_fa (.a(a_sr[0]), .b(b_sr[0]), .cin(carry), .sum(s), .cout(c));
  assign load = bus.start && state != RUN;
  assign last = state == RUN && cnt == CW'(WIDTH - 1);
  always_comb begin
    next = (state == RUN) ? (last ? DONE : RUN) : (bus.start ? RUN : IDLE);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      s_sr   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      state <= next;
      if (load) begin
        a_sr  <= bus.a;
        b_sr  <= bus.b;
        carry <= bus.cin;
        cnt   <= '0;
        s_sr  <= '0;
      end else if (state == RUN) begin
        a_sr  <= a_sr >> 1;
        b_sr  <= b_sr >> 1;
        s_sr  <= {s, s_sr[WIDTH-1:1]};
        carry <= c;
        cnt   <= cnt + CW'(1);
      end
      // result registers capture the final bit directly so they change only on DONE entry
      if (last) begin
        sum_q  <= {s, s_sr[WIDTH-1:1]};
        cout_q <= c;
      end
    end
  end
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed scoreboard bench for serial_adder at WIDTH 8 and exhaustive WIDTH 4
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  logic [8:0] q8[$];
  logic [4:0] q4[$];
  logic [8:0] e8;
  logic [4:0] e4;
  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(4)) if4 ();
  serial_adder #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  serial_adder #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    if8.start = 1'b1;
    if8.a = a;
    if8.b = b;
    if8.cin = cin;
    q8.push_back({1'b0, a} + {1'b0, b} + {8'd0, cin});
  endtask

  // busy for 8 cycles after the accept edge, done on the 9th; optional ignored start at cycle poke
  task automatic collect8(input string tag, input int poke);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if8.start = (i == poke);
      if (i == poke) begin
        if8.a = 8'h77;
        if8.b = 8'h77;
      end
      chk({tag, "_busy"}, {30'd0, if8.busy, if8.done}, 32'd2);
    end
    @(negedge clk);
    if8.start = 1'b0;
    chk({tag, "_done"}, {30'd0, if8.busy, if8.done}, 32'd1);
    e8 = q8.pop_front();
    chk({tag, "_sum"}, {23'd0, if8.cout, if8.sum}, {23'd0, e8});
  endtask

  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    if4.start = 1'b1;
    if4.a = a;
    if4.b = b;
    if4.cin = cin;
    q4.push_back({1'b0, a} + {1'b0, b} + {4'd0, cin});
  endtask

  task automatic collect4();
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if4.start = 1'b0;
      ok &= if4.busy && !if4.done;
    end
    @(negedge clk);
    chk("w4_spacing", {30'd0, ok, if4.done && !if4.busy}, 32'd3);
    e4 = q4.pop_front();
    chk("w4_sum", {27'd0, if4.cout, if4.sum}, {27'd0, e4});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
    if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("reset_idle", {21'd0, if8.busy, if8.done, if8.cout, if8.sum}, 32'd0);
    end
    issue8(8'h5A, 8'h3C, 1'b0);
    collect8("basic", -1);
    repeat (3) @(negedge clk);
    chk("basic_hold", {23'd0, if8.cout, if8.sum}, 32'h096);
    issue8(8'hFF, 8'h01, 1'b0);
    collect8("wrap", -1);
    @(negedge clk);
    issue8(8'h00, 8'h00, 1'b1);
    collect8("cin_only", -1);
    @(negedge clk);
    issue8(8'hFF, 8'hFF, 1'b1);
    collect8("all_ones", -1);
    @(negedge clk);
    issue8(8'h11, 8'h22, 1'b0);
    collect8("ignored_start", 3);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("no_extra_done", {22'd0, if8.done, if8.cout, if8.sum}, 32'h033);
    end
    issue8(8'h05, 8'h06, 1'b1);
    collect8("b2b_first", -1);
    issue8(8'h10, 8'h20, 1'b0);
    collect8("b2b_second", -1);
    @(negedge clk);
    issue8(8'h80, 8'h80, 1'b0);
    repeat (4) begin
      @(negedge clk);
      if8.start = 1'b0;
    end
    rst_n = 1'b0;
    void'(q8.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_reset", {21'd0, if8.busy, if8.done, if8.cout, if8.sum}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_done", {30'd0, if8.busy, if8.done}, 32'd0);
    end
    issue8(8'h80, 8'h80, 1'b0);
    collect8("after_abort", -1);
    @(negedge clk);
    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 2; ci++) begin
          issue4(4'(ai), 4'(bi), 1'(ci));
          collect4();
        end
    chk("queues_drained", q8.size() + q4.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
